// File: rtl/div_unit_pkg.sv
// Shared types and encodings for the multi-cycle divider.
// Also holds the conditional-negate helper used for sign handling.
package div_unit_pkg;

    localparam int unsigned RegBus       = 32;
    localparam int unsigned DoubleRegBus = 64;

    typedef logic [RegBus-1:0]       reg_t;
    typedef logic [DoubleRegBus-1:0] dreg_t;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    // Two's-complement negate when do_neg is set, pass-through otherwise.
    function automatic reg_t cond_neg(input logic do_neg, input reg_t v);
        return do_neg ? reg_t'(~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_iter.sv
// One combinational radix-2 restoring division step on the {rem, quo} pair.
module div_iter
    import div_unit_pkg::*;
(
    input  logic [RegBus:0] rem,
    input  reg_t            quo,
    input  reg_t            divisor,
    output logic [RegBus:0] rem_next,
    output reg_t            quo_next
);

    logic [RegBus:0] rem_shift;
    reg_t            quo_shift;

    always_comb begin
        rem_shift = {rem[RegBus-1:0], quo[RegBus-1]};
        quo_shift = {quo[RegBus-2:0], 1'b0};
        rem_next  = rem_shift;
        quo_next  = quo_shift;
        // Shifted remainder can reach bit 32, so compare rather than trust a borrow bit.
        if (rem_shift >= {1'b0, divisor}) begin
            rem_next = rem_shift - {1'b0, divisor};
            quo_next = {quo_shift[RegBus-1:1], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit signed/unsigned restoring divider for DIV/DIVU.
// DIV_ZERO_FAST_EN: when defined, a zero divisor finishes in 2 cycles with result 0.
module div_unit
    import div_unit_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div,
    input  logic [RegBus-1:0]       opdata1,
    input  logic [RegBus-1:0]       opdata2,
    input  logic                    start,
    input  logic                    annul,
    output logic [DoubleRegBus-1:0] result,
    output logic                    ready
);

    div_state_e      state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [RegBus:0] rem_q, rem_d, rem_step;
    reg_t            quo_q, quo_d, quo_step;
    reg_t            divisor_q, divisor_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    dreg_t           result_q, result_d;
    logic            ready_q, ready_d;
    logic            zero_fast;

`ifdef DIV_ZERO_FAST_EN
    assign zero_fast = (opdata2 == '0);
`else
    assign zero_fast = 1'b0;
`endif

    div_iter u_div_iter (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (divisor_q),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        case (state_q)
            DivFree: begin
                if (start == DivStart && !annul) begin
                    if (zero_fast) begin
                        state_d = DivByZero;
                    end else begin
                        rem_d     = '0;
                        quo_d     = cond_neg(signed_div & opdata1[RegBus-1], opdata1);
                        divisor_d = cond_neg(signed_div & opdata2[RegBus-1], opdata2);
                        neg_quo_d = signed_div & (opdata1[RegBus-1] ^ opdata2[RegBus-1]);
                        neg_rem_d = signed_div & opdata1[RegBus-1];
                        cnt_d     = '0;
                        state_d   = DivOn;
                    end
                end
            end
`ifdef DIV_ZERO_FAST_EN
            DivByZero: begin
                result_d = '0;
                ready_d  = DivResultReady;
                state_d  = DivEnd;
            end
`endif
            DivOn: begin
                if (annul) begin
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                    state_d  = DivFree;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result_d = {cond_neg(neg_rem_q, rem_step[RegBus-1:0]),
                                    cond_neg(neg_quo_q, quo_step)};
                        ready_d  = DivResultReady;
                        state_d  = DivEnd;
                    end
                end
            end
            DivEnd: begin
                if (start == DivStop) begin
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                    state_d  = DivFree;
                end
            end
            default: begin
                state_d = DivFree;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result = result_q;
    assign ready  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit; each scenario task checks its own results.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready)
    );

    // Raise start at a negedge and count rising edges until ready (bounded).
    task automatic issue(input logic sd, input logic [31:0] a, input logic [31:0] b,
                         input int budget, output int edges);
        @(negedge clk);
        signed_div = sd;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        edges      = 0;
        while (ready !== 1'b1 && edges < budget) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    // Drop start and let DONE return to IDLE.
    task automatic release_op();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        start      = 1'b0;
        annul      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 0", ready);
        end
        n_tests++;
        if (result !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_result: got %h expected 0", result);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_unsigned();
        int e;
        issue(1'b0, 32'd100, 32'd7, 40, e);
        n_tests++;
        if (e !== 33) begin
            n_fail++;
            $display("FAIL udiv_latency: got %0d expected 33", e);
        end
        n_tests++;
        if (result !== {32'd2, 32'd14}) begin
            n_fail++;
            $display("FAIL udiv_100_7: got %h expected %h", result, {32'd2, 32'd14});
        end
        release_op();
        n_tests++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            n_fail++;
            $display("FAIL udiv_release: got ready=%b result=%h expected 0/0", ready, result);
        end
    endtask

    task automatic test_signed();
        int e;
        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 40, e);
        n_tests++;
        if (e !== 33) begin
            n_fail++;
            $display("FAIL sdiv_latency: got %0d expected 33", e);
        end
        n_tests++;
        if (result !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
            n_fail++;
            $display("FAIL sdiv_m7_2: got %h expected ffffffff_fffffffd", result);
        end
        release_op();
        issue(1'b0, 32'hFFFF_FFF9, 32'd2, 40, e);
        n_tests++;
        if (e !== 33) begin
            n_fail++;
            $display("FAIL udiv_big_latency: got %0d expected 33", e);
        end
        n_tests++;
        if (result !== {32'd1, 32'h7FFF_FFFC}) begin
            n_fail++;
            $display("FAIL udiv_fffffff9_2: got %h expected 00000001_7ffffffc", result);
        end
        release_op();
    endtask

    task automatic test_annul();
        int e;
        int seen;
        @(negedge clk);
        signed_div = 1'b0;
        opdata1    = 32'd50;
        opdata2    = 32'd5;
        start      = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            n_fail++;
            $display("FAIL annul_abort: got ready=%b result=%h expected 0/0", ready, result);
        end
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        seen  = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL annul_no_ready: got %0d ready cycles expected 0", seen);
        end
        issue(1'b0, 32'd9, 32'd3, 40, e);
        n_tests++;
        if (e !== 33) begin
            n_fail++;
            $display("FAIL annul_next_latency: got %0d expected 33", e);
        end
        n_tests++;
        if (result !== {32'd0, 32'd3}) begin
            n_fail++;
            $display("FAIL annul_next_9_3: got %h expected 00000000_00000003", result);
        end
        release_op();
    endtask

    task automatic test_div_zero();
        int e;
        logic [63:0] exp_u, exp_s;
        int          exp_e;
`ifdef DIV_ZERO_FAST_EN
        exp_e = 2;
        exp_u = 64'h0;
        exp_s = 64'h0;
`else
        exp_e = 33;
        exp_u = {32'd5, 32'hFFFF_FFFF};
        exp_s = {32'hFFFF_FFFB, 32'h0000_0001};
`endif
        issue(1'b0, 32'd5, 32'd0, 40, e);
        n_tests++;
        if (e !== exp_e) begin
            n_fail++;
            $display("FAIL divzero_u_latency: got %0d expected %0d", e, exp_e);
        end
        n_tests++;
        if (result !== exp_u) begin
            n_fail++;
            $display("FAIL divzero_u_result: got %h expected %h", result, exp_u);
        end
        release_op();
        issue(1'b1, 32'hFFFF_FFFB, 32'd0, 40, e);
        n_tests++;
        if (e !== exp_e) begin
            n_fail++;
            $display("FAIL divzero_s_latency: got %0d expected %0d", e, exp_e);
        end
        n_tests++;
        if (result !== exp_s) begin
            n_fail++;
            $display("FAIL divzero_s_result: got %h expected %h", result, exp_s);
        end
        release_op();
    endtask

    task automatic test_done_hold();
        int e;
        issue(1'b0, 32'd1000, 32'd10, 40, e);
        n_tests++;
        if (e !== 33 || result !== {32'd0, 32'd100}) begin
            n_fail++;
            $display("FAIL hold_first: got edges=%0d result=%h expected 33/00000000_00000064",
                     e, result);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (ready !== 1'b1 || result !== {32'd0, 32'd100}) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got ready=%b result=%h expected 1/00000000_00000064",
                         i, ready, result);
            end
        end
        release_op();
        n_tests++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            n_fail++;
            $display("FAIL hold_release: got ready=%b result=%h expected 0/0", ready, result);
        end
    endtask

    task automatic test_rst_mid_run();
        int e;
        // Async clear while holding a completed result.
        issue(1'b0, 32'd100, 32'd7, 40, e);
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            n_fail++;
            $display("FAIL rst_in_done: got ready=%b result=%h expected 0/0", ready, result);
        end
        @(negedge clk);
        rst = 1'b1;
        // Async clear in the middle of an iteration sequence.
        @(negedge clk);
        opdata1 = 32'd77;
        opdata2 = 32'd3;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            n_fail++;
            $display("FAIL rst_in_run: got ready=%b result=%h expected 0/0", ready, result);
        end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 40, e);
        n_tests++;
        if (e !== 33) begin
            n_fail++;
            $display("FAIL rst_next_latency: got %0d expected 33", e);
        end
        n_tests++;
        if (result !== {32'h0, 32'h8000_0000}) begin
            n_fail++;
            $display("FAIL sdiv_min_m1: got %h expected 00000000_80000000", result);
        end
        release_op();
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_annul();
        test_div_zero();
        test_done_hold();
        test_rst_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider used by the EX stage for DIV/DIVU (aluop `EXE_DIV_OP`/`EXE_DIVU_OP`), with operands already resolved by ID forwarding. EX raises `start`, holds its pipeline stall request until `ready`, then writes `result` into HI/LO. The divider uses a radix-2 restoring algorithm: one quotient bit per cycle, 32 iterations, with sign correction for signed division.

## Interface
- No parameters; data width fixed at 32 (`RegBus`).
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `signed_div` in 1: 1 = signed (DIV), 0 = unsigned (DIVU). Sampled with `start`.
- `opdata1` in 32: dividend. Sampled with `start`.
- `opdata2` in 32: divisor. Sampled with `start`.
- `start` in 1: request. Must stay high until `ready` has been consumed.
- `annul` in 1: abort the current operation (branch flush / exception).
- `result` out 64: {remainder[63:32], quotient[31:0]}. Remainder goes to HI, quotient to LO.
- `ready` out 1: `result` is valid.

## Operation
- States: IDLE, BYZERO, RUN, DONE.
- Reset values: state=IDLE, `result`=0, `ready`=0, counter=0, internal remainder/quotient=0.
- **IDLE**
  - If `start`=1 and `annul`=0:
    - If `opdata2`=0, go to BYZERO.
    - Otherwise latch |opdata1| and |opdata2| (two's-complement negate when `signed_div` and bit31=1; raw values when unsigned), latch the sign flags, clear the counter, go to RUN.
  - Otherwise stay in IDLE.
- **RUN**
  - Each edge performs one iteration: shift {rem,quo} left by 1; if rem ≥ divisor, subtract it and set the quotient LSB; increment the counter.
  - The edge that completes iteration 32 does all of the following:
    - Negate the quotient if signed and sign(dividend)≠sign(divisor).
    - Negate the remainder if signed and the dividend is negative.
    - Register `result`, set `ready`=1, go to DONE.
  - `annul`=1 at any RUN edge: go to IDLE, `ready`=0, `result`=0. The annul has priority over the iteration.
- **BYZERO**
  - One cycle, then go to DONE with `result`=0 and `ready`=1.
- **DONE**
  - Hold `result` and `ready`=1 while `start`=1.
  - The first edge with `start`=0: go to IDLE, `ready`=0, `result`=0.
  - `annul` is ignored in DONE; EX drops `start` itself.
- Arithmetic: the remainder datapath is 33 bits so the subtraction borrow is captured without overflow.
  - 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0. There is no trap.

## Timing
- Divisor ≠ 0: `start` is sampled at edge E0, iterations run at E1..E32, and `ready`=1 after E32. Latency is 33 cycles.
- Divisor = 0 (macro on): `ready`=1 after E1. Latency is 2 cycles.
- `result` is registered and stable for the whole time `ready`=1.
- A new operation is accepted no earlier than the first IDLE cycle after DONE, so back-to-back divides have one bubble.
- `rst` asserted at any time: state returns to IDLE and outputs clear immediately (asynchronous). Deassertion is synchronous to `clk`.

## Configuration
- `DIV_ZERO_FAST_EN` defined: BYZERO exists; a zero divisor completes in 2 cycles with `result`=64'h0.
- `DIV_ZERO_FAST_EN` undefined: there is no BYZERO state; a zero divisor runs the full 33 cycles through RUN. The natural algorithm output is then:
  - Unsigned: quotient 0xFFFFFFFF, remainder = dividend.
  - Signed: quotient 0xFFFFFFFF when the dividend is non-negative, 0x00000001 when negative; remainder = dividend.

## Structure
- Shared defines file gets:
  - State encodings `DivFree`, `DivByZero`, `DivOn`, `DivEnd`.
  - `DivResultReady`/`DivResultNotReady`.
  - `DivStart`/`DivStop`.
  - `DoubleRegBus` (63:0).
- Sub-module `div_iter`: purely combinational single restoring step. Takes 33-bit partial remainder, 32-bit quotient and divisor; returns the next remainder and quotient. It is instantiated once, and the FSM/counter stays in `div_unit`.

## Test plan
- Unsigned 100/7: `ready` rises exactly 33 cycles after `start` → `result` = {32'd2, 32'd14}.
- Signed −7/2 (0xFFFFFFF9 / 2): → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - Repeating as unsigned gives quotient 0x7FFFFFFC, remainder 1.
- `annul` pulsed at cycle 10 of RUN → IDLE next cycle, `ready` never rises.
  - A following 9/3 then completes with quotient 3, remainder 0.
- Divisor 0, dividend 5, unsigned:
  - Macro on → `ready` after 2 cycles, `result`=0.
  - Macro off → 33 cycles, quotient 0xFFFFFFFF, remainder 5.
- `start` held 5 cycles in DONE → `result` stable and `ready`=1 throughout.
  - `start` low → `ready`=0 the next cycle.
- `rst`=0 asserted mid-RUN (cycle 20) → `ready`=0 and `result`=0 immediately.
  - After release, a fresh 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0.
